// File: rtl/cla_pkg.sv
// Shared constants, flag bundle and overflow helper for the pipelined CLA adder.
// Saturation bounds are only consumed when CLA_PIPE_SAT_EN is defined.
package cla_pkg;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_BLOCK  = 8;
  localparam int DEF_STAGES = 2;

  // Saturation bounds are sliced from this all-ones magnitude to the configured width.
  localparam int SAT_MAX_WIDTH = 256;
  localparam logic [SAT_MAX_WIDTH-1:0] SAT_MAG_ONES = '1;

  typedef struct packed {
    logic c_out;
    logic ovf;
    logic zero;
  } cla_flags_t;

  function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/cla_block.sv
// BLOCK-bit carry-lookahead slice: local sum plus group generate/propagate.
module cla_block
  import cla_pkg::*;
#(
  parameter int BLOCK = DEF_BLOCK
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             cin,
  output logic [BLOCK-1:0] sum,
  output logic             G,
  output logic             P
);

  logic [BLOCK-1:0] gen_s;
  logic [BLOCK-1:0] prop_s;
  logic             carry_s;

  assign gen_s  = a & b;
  assign prop_s = a ^ b;
  assign P      = &prop_s;

  // Group generate kept apart from the sum so it never depends on cin.
  always_comb begin
    G = 1'b0;
    for (int i = 0; i < BLOCK; i++) begin
      G = gen_s[i] | (prop_s[i] & G);
    end
  end

  // Local sum bits from the incoming block carry.
  always_comb begin
    carry_s = cin;
    sum     = '0;
    for (int i = 0; i < BLOCK; i++) begin
      sum[i]  = prop_s[i] ^ carry_s;
      carry_s = gen_s[i] | (prop_s[i] & carry_s);
    end
  end

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor with valid/ready flow control.
// Define CLA_PIPE_SAT_EN to saturate the sum on signed overflow.
module pipelined_cla_adder
  import cla_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int BLOCK  = DEF_BLOCK,
  parameter int STAGES = DEF_STAGES
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf,
  output logic             zero
);

  localparam int NB   = WIDTH / BLOCK;
  localparam int BPS  = NB / STAGES;
  localparam int PR   = (STAGES > 1) ? STAGES - 1 : 1;
  localparam int LAST = STAGES - 1;

`ifdef CLA_PIPE_SAT_EN
  localparam logic [WIDTH-1:0] SAT_POS = {1'b0, SAT_MAG_ONES[WIDTH-2:0]};
  localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, ~SAT_MAG_ONES[WIDTH-2:0]};
`endif

  logic             advance_s;
  logic [WIDTH-1:0] st_a [STAGES];
  logic [WIDTH-1:0] st_b [STAGES];
  logic [WIDTH-1:0] st_s [STAGES];
  logic             st_c [STAGES];
  logic             st_v [STAGES];
  logic [WIDTH-1:0] so_s [STAGES];
  logic             so_c [STAGES];

  logic [BLOCK-1:0] blk_sum [NB];
  logic             blk_g   [NB];
  logic             blk_p   [NB];
  logic             blk_cin [NB];
  logic             chain_c_s;

  logic [WIDTH-1:0] pa_q [PR];
  logic [WIDTH-1:0] pa_d [PR];
  logic [WIDTH-1:0] pb_q [PR];
  logic [WIDTH-1:0] pb_d [PR];
  logic [WIDTH-1:0] ps_q [PR];
  logic [WIDTH-1:0] ps_d [PR];
  logic             pc_q [PR];
  logic             pc_d [PR];
  logic             pv_q [PR];
  logic             pv_d [PR];

  logic [WIDTH-1:0] raw_s;
  logic [WIDTH-1:0] res_s;
  logic             ovf_s;
  logic [WIDTH-1:0] sum_q, sum_d;
  cla_flags_t       flags_q, flags_d;
  logic             out_valid_q, out_valid_d;

  assign advance_s = ~out_valid_q | out_ready;
  assign in_ready  = advance_s;

  // Subtraction is A + ~B + 1.
  assign st_a[0] = dataA;
  assign st_b[0] = sub ? ~dataB : dataB;
  assign st_s[0] = '0;
  assign st_c[0] = sub ? 1'b1 : c_in;
  assign st_v[0] = in_valid;

  genvar gs, gk;
  for (gs = 1; gs < STAGES; gs++) begin : g_link
    assign st_a[gs] = pa_q[gs-1];
    assign st_b[gs] = pb_q[gs-1];
    assign st_s[gs] = ps_q[gs-1];
    assign st_c[gs] = pc_q[gs-1];
    assign st_v[gs] = pv_q[gs-1];
  end

  for (gs = 0; gs < STAGES; gs++) begin : g_stage
    for (gk = 0; gk < BPS; gk++) begin : g_blk
      localparam int J = gs * BPS + gk;
      cla_block #(.BLOCK(BLOCK)) u_blk (
        .a   (st_a[gs][J*BLOCK +: BLOCK]),
        .b   (st_b[gs][J*BLOCK +: BLOCK]),
        .cin (blk_cin[J]),
        .sum (blk_sum[J]),
        .G   (blk_g[J]),
        .P   (blk_p[J])
      );
    end
  end

  // Inter-block carry chain, restarting from each stage's registered carry.
  always_comb begin
    chain_c_s = 1'b0;
    for (int i = 0; i < STAGES; i++) begin
      chain_c_s = st_c[i];
      for (int j = 0; j < BPS; j++) begin
        blk_cin[i*BPS + j] = chain_c_s;
        chain_c_s          = blk_g[i*BPS + j] | (blk_p[i*BPS + j] & chain_c_s);
      end
      so_c[i] = chain_c_s;
    end
  end

  // Each stage overlays its block sums onto the partial sum it received.
  always_comb begin
    for (int i = 0; i < STAGES; i++) begin
      so_s[i] = st_s[i];
      for (int j = 0; j < BPS; j++) begin
        so_s[i][(i*BPS + j)*BLOCK +: BLOCK] = blk_sum[i*BPS + j];
      end
    end
  end

  // Inter-stage registers advance together, bubbles included.
  always_comb begin
    for (int i = 0; i < PR; i++) begin
      pa_d[i] = pa_q[i];
      pb_d[i] = pb_q[i];
      ps_d[i] = ps_q[i];
      pc_d[i] = pc_q[i];
      pv_d[i] = pv_q[i];
    end
    for (int i = 0; i < STAGES - 1; i++) begin
      if (advance_s) begin
        pa_d[i] = st_a[i];
        pb_d[i] = st_b[i];
        ps_d[i] = so_s[i];
        pc_d[i] = so_c[i];
        pv_d[i] = st_v[i];
      end else begin
        pa_d[i] = pa_q[i];
        pb_d[i] = pb_q[i];
        ps_d[i] = ps_q[i];
        pc_d[i] = pc_q[i];
        pv_d[i] = pv_q[i];
      end
    end
  end

  // Final stage: overflow, optional saturation, zero flag on the delivered sum.
  always_comb begin
    raw_s = so_s[LAST];
    ovf_s = signed_ovf(st_a[LAST][WIDTH-1], st_b[LAST][WIDTH-1], raw_s[WIDTH-1]);
`ifdef CLA_PIPE_SAT_EN
    if (ovf_s) begin
      res_s = st_a[LAST][WIDTH-1] ? SAT_NEG : SAT_POS;
    end else begin
      res_s = raw_s;
    end
`else
    res_s = raw_s;
`endif
    if (advance_s) begin
      out_valid_d   = st_v[LAST];
      sum_d         = res_s;
      flags_d.c_out = so_c[LAST];
      flags_d.ovf   = ovf_s;
      flags_d.zero  = (res_s == '0);
    end else begin
      out_valid_d = out_valid_q;
      sum_d       = sum_q;
      flags_d     = flags_q;
    end
  end

  // State update; reset discards everything in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < PR; i++) begin
        pa_q[i] <= '0;
        pb_q[i] <= '0;
        ps_q[i] <= '0;
        pc_q[i] <= 1'b0;
        pv_q[i] <= 1'b0;
      end
      sum_q       <= '0;
      flags_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      for (int i = 0; i < PR; i++) begin
        pa_q[i] <= pa_d[i];
        pb_q[i] <= pb_d[i];
        ps_q[i] <= ps_d[i];
        pc_q[i] <= pc_d[i];
        pv_q[i] <= pv_d[i];
      end
      sum_q       <= sum_d;
      flags_q     <= flags_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign c_out     = flags_q.c_out;
  assign ovf       = flags_q.ovf;
  assign zero      = flags_q.zero;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Self-checking bench: directed corners, stall/reset scenarios and randomized traffic
// against an arithmetic reference model; a second instance uses STAGES=4.
module tb_pipelined_cla_adder;

`ifdef CLA_PIPE_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic        in_valid, in_ready, c_in, sub, out_valid, out_ready, c_out, ovf, zero;
  logic [31:0] dataA, dataB, sum;
  logic        in_valid4, in_ready4, c_in4, sub4, out_valid4, out_ready4, c_out4, ovf4, zero4;
  logic [31:0] dataA4, dataB4, sum4;

  pipelined_cla_adder dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .dataA(dataA), .dataB(dataB), .c_in(c_in), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
    .c_out(c_out), .ovf(ovf), .zero(zero)
  );

  pipelined_cla_adder #(.WIDTH(32), .BLOCK(8), .STAGES(4)) dut4 (
    .clock(clock), .reset(reset), .in_valid(in_valid4), .in_ready(in_ready4),
    .dataA(dataA4), .dataB(dataB4), .c_in(c_in4), .sub(sub4),
    .out_valid(out_valid4), .out_ready(out_ready4), .sum(sum4),
    .c_out(c_out4), .ovf(ovf4), .zero(zero4)
  );

  typedef struct {
    logic [31:0] s;
    logic        c;
    logic        o;
    logic        z;
  } res_t;

  res_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   ncons    = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic, signed range test for overflow.
  function automatic res_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic ci, input logic sb);
    res_t   r;
    longint sa, sbv, ss;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    if (sb) begin
      r.s = a - b;
      r.c = (a >= b);
      ss  = sa - sbv;
    end else begin
      {r.c, r.s} = {1'b0, a} + {1'b0, b} + 33'(ci);
      ss = sa + sbv + longint'(ci);
    end
    r.o = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
    if (SAT && r.o) r.s = (ss > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
    r.z = (r.s == 32'h0);
    return r;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h7FFF_FFFF;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h0000_0000;
      default: return $urandom();
    endcase
  endfunction

  // One clock of scoreboarded traffic on the STAGES=2 instance.
  task automatic cyc(input bit exp_stall, output bit acc);
    res_t e;
    @(negedge clock);
    acc = in_valid && in_ready;
    if (exp_stall) chk("stall_in_ready", 64'(in_ready), 64'd0);
    if (out_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_result", 64'(out_valid), 64'd0);
      end else begin
        e = q[0];
        chk("q_sum", 64'(sum), 64'(e.s));
        chk("q_c_out", 64'(c_out), 64'(e.c));
        chk("q_ovf", 64'(ovf), 64'(e.o));
        chk("q_zero", 64'(zero), 64'(e.z));
        if (out_ready) begin
          void'(q.pop_front());
          ncons++;
        end
      end
    end
    if (acc) q.push_back(model(dataA, dataB, c_in, sub));
    @(posedge clock); #1;
  endtask

  task automatic dir(input string tag, input logic [31:0] a, input logic [31:0] b,
                     input logic ci, input logic sb, input logic [31:0] es,
                     input logic ec, input logic eo, input logic ez);
    int lat;
    lat = 0;
    dataA = a; dataB = b; c_in = ci; sub = sb; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clock);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clock); #1;
    in_valid = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clock);
      if (out_valid) begin
        lat = i;
        break;
      end
      @(posedge clock); #1;
    end
    chk({tag, "_latency"}, 64'(lat), 64'd2);
    chk({tag, "_sum"}, 64'(sum), 64'(es));
    chk({tag, "_c_out"}, 64'(c_out), 64'(ec));
    chk({tag, "_ovf"}, 64'(ovf), 64'(eo));
    chk({tag, "_zero"}, 64'(zero), 64'(ez));
    @(posedge clock); #1;
  endtask

  task automatic dir4(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic ci, input logic [31:0] es, input logic ec, input logic ez);
    int lat;
    lat = 0;
    dataA4 = a; dataB4 = b; c_in4 = ci; sub4 = 1'b0; in_valid4 = 1'b1; out_ready4 = 1'b1;
    @(negedge clock);
    chk({tag, "_in_ready"}, 64'(in_ready4), 64'd1);
    @(posedge clock); #1;
    in_valid4 = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clock);
      if (out_valid4) begin
        lat = i;
        break;
      end
      @(posedge clock); #1;
    end
    chk({tag, "_latency"}, 64'(lat), 64'd4);
    chk({tag, "_sum"}, 64'(sum4), 64'(es));
    chk({tag, "_c_out"}, 64'(c_out4), 64'(ec));
    chk({tag, "_zero"}, 64'(zero4), 64'(ez));
    @(posedge clock); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] stall_a [4];
    logic [31:0] stall_b [4];
    bit          acc, acc_prev;
    int          idx;

    in_valid = 1'b0; dataA = 32'h0; dataB = 32'h0; c_in = 1'b0; sub = 1'b0; out_ready = 1'b1;
    in_valid4 = 1'b0; dataA4 = 32'h0; dataB4 = 32'h0; c_in4 = 1'b0; sub4 = 1'b0; out_ready4 = 1'b1;

    repeat (2) @(posedge clock);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_sum", 64'(sum), 64'd0);
    chk("rst_c_out", 64'(c_out), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    chk("rst_zero", 64'(zero), 64'd0);
    reset = 1'b0;
    @(negedge clock);
    chk("ready_after_reset", 64'(in_ready), 64'd1);
    @(posedge clock); #1;

    dir("wrap_add", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    dir("sub_5_7", 32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    dir("sub_7_5", 32'd7, 32'd5, 1'b0, 1'b1, 32'h0000_0002, 1'b1, 1'b0, 1'b0);
    dir("sub_eq", 32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 1'b1);
    dir("pos_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0,
        SAT ? 32'h7FFF_FFFF : 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    dir("neg_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0,
        SAT ? 32'h8000_0000 : 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
    dir("sub_ovf", 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1,
        SAT ? 32'h8000_0000 : 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
    dir("stage_carry", 32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0);
    dir("carry_in", 32'h0000_00FF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0);
    dir("sub_ign_cin", 32'd7, 32'd5, 1'b1, 1'b1, 32'h0000_0002, 1'b1, 1'b0, 1'b0);

    // Four back-to-back operands with the consumer stalled for three cycles.
    stall_a[0] = 32'h1234_5678; stall_b[0] = 32'h0FED_CBA9;
    stall_a[1] = 32'hFFFF_0000; stall_b[1] = 32'h0001_0000;
    stall_a[2] = 32'h8000_0001; stall_b[2] = 32'h8000_0001;
    stall_a[3] = 32'h0F0F_0F0F; stall_b[3] = 32'h7070_7070;
    idx = 0; ncons = 0;
    for (int c = 0; c < 14; c++) begin
      out_ready = !(c >= 2 && c <= 4);
      in_valid  = (idx < 4);
      if (idx < 4) begin
        dataA = stall_a[idx]; dataB = stall_b[idx]; sub = idx[0]; c_in = idx[1];
      end
      cyc(c >= 2 && c <= 4, acc);
      if (acc) idx++;
    end
    chk("stall_accepted", 64'(idx), 64'd4);
    chk("stall_results", 64'(ncons), 64'd4);
    chk("stall_drained", 64'(q.size()), 64'd0);

    // Randomized traffic with random back-pressure; operands held until accepted.
    acc_prev = 1'b1;
    in_valid = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!in_valid || acc_prev) begin
        in_valid = ($urandom_range(0, 3) != 0);
        dataA = pick();
        dataB = ($urandom_range(0, 7) == 0) ? dataA : pick();
        sub   = 1'($urandom_range(0, 1));
        c_in  = 1'($urandom_range(0, 1));
      end
      out_ready = ($urandom_range(0, 3) != 0);
      cyc(1'b0, acc);
      acc_prev = acc;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 8; c++) cyc(1'b0, acc);
    chk("random_drained", 64'(q.size()), 64'd0);

    // Reset with two operations in flight.
    out_ready = 1'b0; in_valid = 1'b1;
    dataA = 32'h0000_0011; dataB = 32'h0000_0022; sub = 1'b0; c_in = 1'b0;
    cyc(1'b0, acc);
    dataA = 32'h0000_0033; dataB = 32'h0000_0044;
    cyc(1'b0, acc);
    in_valid = 1'b0;
    chk("rstmid_pre_valid", 64'(out_valid), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("rstmid_out_valid", 64'(out_valid), 64'd0);
    chk("rstmid_sum", 64'(sum), 64'd0);
    chk("rstmid_zero", 64'(zero), 64'd0);
    q.delete();
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    chk("rstmid_in_ready", 64'(in_ready), 64'd1);
    @(posedge clock); #1;
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      chk("rstmid_no_result", 64'(out_valid), 64'd0);
      @(posedge clock); #1;
    end

    // Four-stage instance: carry ripples across every stage boundary.
    dir4("s4_carry", 32'h00FF_FFFF, 32'h0000_0001, 1'b0, 32'h0100_0000, 1'b0, 1'b0);
    dir4("s4_wrap", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipelined_cla_adder.md
PIPELINED_CLA_ADDER -- requirements
Module: pipelined_cla_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits.
REQ-002 SHALL have parameter BLOCK, default 8, lookahead block width in bits; WIDTH % BLOCK == 0.
REQ-003 SHALL have parameter STAGES, default 2, pipeline register stages. NB = WIDTH/BLOCK; NB % STAGES == 0; 1 <= STAGES <= NB.
REQ-004 SHALL have port clock, input, 1, sole clock; all state rising-edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port in_valid, input, 1, operands present.
REQ-007 SHALL have port in_ready, output, 1, operands accepted this cycle when in_valid && in_ready.
REQ-008 SHALL have ports dataA and dataB, input, WIDTH, operands.
REQ-009 SHALL have port c_in, input, 1, carry-in (add only).
REQ-010 SHALL have port sub, input, 1, 1 = dataA - dataB.
REQ-011 SHALL have port out_valid, output, 1, result present.
REQ-012 SHALL have port out_ready, input, 1, consumer accepts result.
REQ-013 SHALL have port sum, output, WIDTH, result.
REQ-014 SHALL have ports c_out, ovf and zero, output, 1 each: carry-out, signed overflow, sum == 0.

Function
REQ-015 SHALL use effective B = sub ? ~dataB : dataB and effective carry-in = sub ? 1 : c_in.
REQ-016 SHALL compute per-block G/P with BLOCK-bit lookahead; inter-block carry = G | (P & carry_prev).
REQ-017 SHALL evaluate NB/STAGES consecutive blocks (LSB first) per stage, registering partial sums, carry and still-unused operand bits between stages.
REQ-018 SHALL define advance = ~out_valid | out_ready; all stage registers (data and valid) load only when advance = 1.
REQ-019 SHALL drive in_ready = advance, combinationally.
REQ-020 SHALL present a result exactly STAGES cycles after acceptance when advance stays 1; stalls add cycles, with no loss, duplication or reordering.
REQ-021 SHALL propagate bubbles as invalid stages; bubbles are not collapsed.
REQ-022 SHALL hold sum, c_out, ovf, zero and out_valid stable while out_valid && ~out_ready.
REQ-023 SHALL set c_out to the carry out of bit WIDTH-1; for sub, c_out = 1 means no borrow.
REQ-024 SHALL set ovf = (A[msb] == B_eff[msb]) && (raw_sum[msb] != A[msb]).
REQ-025 SHALL compute zero on the final (post-configuration) sum.
REQ-026 SHALL accept a new operand in the same cycle a result is consumed when the pipe is full (full throughput).

Reset
REQ-027 SHALL clear all valid bits on reset assertion, asynchronously; out_valid = 0 while reset is high.
REQ-028 SHALL reset sum = 0, c_out = 0, ovf = 0, zero = 0.
REQ-029 SHALL discard in-flight operations on reset mid-operation; none emerge after release.
REQ-030 SHALL drive in_ready = 1 in the first cycle after reset release.

Configuration
REQ-031 SHALL, with CLA_PIPE_SAT_EN defined, replace sum on ovf with signed saturation: 0x7F..F when A[msb] = 0, 0x80..0 when A[msb] = 1; c_out unchanged, ovf still reported.
REQ-032 SHALL, without CLA_PIPE_SAT_EN, output the wrapped sum with no saturation logic.

Structure
REQ-033 SHALL take default WIDTH/BLOCK/STAGES constants and the saturation bound constants from shared package cla_pkg.
REQ-034 SHALL instantiate sub-module cla_block (BLOCK-bit lookahead adder with inputs a, b, cin and outputs sum, G, P) NB times.

Verification (WIDTH=32, BLOCK=8, STAGES=2 unless stated)
REQ-035 SHALL check: 0xFFFFFFFF + 0x00000001, c_in=0 -> sum 0x00000000, c_out 1, zero 1, ovf 0, out_valid exactly 2 cycles after accept.
REQ-036 SHALL check: sub, 5 - 7 -> sum 0xFFFFFFFE, c_out 0, ovf 0; sub, 7 - 5 -> 0x00000002, c_out 1.
REQ-037 SHALL check: 0x7FFFFFFF + 1 -> ovf 1; sum 0x80000000 without macro, 0x7FFFFFFF with CLA_PIPE_SAT_EN.
REQ-038 SHALL check: 4 back-to-back operands with out_ready low 3 cycles -> in_ready low once the pipe is full, all 4 results in order, values unchanged while held.
REQ-039 SHALL check: reset asserted with 2 operations in flight -> out_valid 0 immediately, no result after release, in_ready 1 next cycle.
REQ-040 SHALL check: STAGES=4, 0x00FFFFFF + 0x00000001 -> 0x01000000, latency 4, carry crossing every stage boundary.
